// File: rtl/seq_digit_adder.sv
// seq_digit_adder: multi-cycle digit-serial add/subtract with start/busy/done handshake
//   Params : WIDTH operand width, DIGIT bits per cycle (must divide WIDTH)
//   Inputs : clk, rst_n (async, active-low), start, sub, in1, in2, cin
//   Outputs: busy, done (1-cycle pulse), out, carry_out
//            overflow, zero only when ADDER_FLAGS_EN is defined
module seq_digit_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
`ifdef ADDER_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d, res_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, busy_q, busy_d, done_q, done_d, carry_q, carry_d;
  logic [DIGIT:0] sum;
  logic last;
`ifdef ADDER_FLAGS_EN
  logic ovf_q, ovf_d, zero_q, zero_d, msb_c;
`endif
  always_comb begin
    sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    // new digit enters at the MSB end; after STEPS digits the LSD sits at bit 0
    res_n = WIDTH'({sum[DIGIT-1:0], res_q} >> DIGIT);
    last = cnt_q == CW'(STEPS - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    res_d = res_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    out_d = out_q;
    carry_d = carry_q;
`ifdef ADDER_FLAGS_EN
    // carry into the MSB is recovered from the top sum bit of the last digit
    msb_c = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];
    ovf_d = ovf_q;
    zero_d = zero_q;
`endif
    if (start && state_q != RUN) begin
      state_d = RUN;
      a_d = in1;
      b_d = sub ? ~in2 : in2;
      c_d = sub | cin;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (state_q == RUN) begin
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      c_d = sum[DIGIT];
      res_d = res_n;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
        out_d = res_n;
        carry_d = sum[DIGIT];
`ifdef ADDER_FLAGS_EN
        ovf_d = msb_c ^ sum[DIGIT];
        zero_d = res_n == '0;
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q <= '0;
      carry_q <= 1'b0;
`ifdef ADDER_FLAGS_EN
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      out_q <= out_d;
      carry_q <= carry_d;
`ifdef ADDER_FLAGS_EN
      ovf_q <= ovf_d;
      zero_q <= zero_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign out = out_q;
  assign carry_out = carry_q;
`ifdef ADDER_FLAGS_EN
  assign overflow = ovf_q;
  assign zero = zero_q;
`endif
endmodule

// File: tb/tb_seq_digit_adder.sv
// tb_seq_digit_adder: directed self-checking bench for seq_digit_adder (32/4, 8/8, 8/1)
module tb_seq_digit_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic start, sub, cin, busy, done, co;
  logic [31:0] in1, in2, out;
  logic start_a, sub_a, cin_a, busy_a, done_a, co_a;
  logic [7:0] in1_a, in2_a, out_a;
  logic start_b, sub_b, cin_b, busy_b, done_b, co_b;
  logic [7:0] in1_b, in2_b, out_b;
`ifdef ADDER_FLAGS_EN
  logic ov, zr, ov_a, zr_a, ov_b, zr_b;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_digit_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy), .done(done), .out(out), .carry_out(co)
`ifdef ADDER_FLAGS_EN
    , .overflow(ov), .zero(zr)
`endif
  );
  seq_digit_adder #(.WIDTH(8), .DIGIT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sub(sub_a), .in1(in1_a), .in2(in2_a), .cin(cin_a),
    .busy(busy_a), .done(done_a), .out(out_a), .carry_out(co_a)
`ifdef ADDER_FLAGS_EN
    , .overflow(ov_a), .zero(zr_a)
`endif
  );
  seq_digit_adder #(.WIDTH(8), .DIGIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sub(sub_b), .in1(in1_b), .in2(in2_b), .cin(cin_b),
    .busy(busy_b), .done(done_b), .out(out_b), .carry_out(co_b)
`ifdef ADDER_FLAGS_EN
    , .overflow(ov_b), .zero(zr_b)
`endif
  );

  task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic ci,
                      output int lat);
    start = 1'b1; sub = s; in1 = a; in2 = b; cin = ci;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 0; sub = 0; cin = 0; in1 = 0; in2 = 0;
    start_a = 0; sub_a = 0; cin_a = 0; in1_a = 0; in2_a = 0;
    start_b = 0; sub_b = 0; cin_b = 0; in1_b = 0; in2_b = 0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, co} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b exp=000", {busy, done, co}); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
    total++; if ({busy_a, done_a, out_a, busy_b, done_b, out_b} !== 20'h0) begin bad++; $display("FAIL reset_small got=%h exp=0", {busy_a, done_a, out_a, busy_b, done_b, out_b}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat;
    op32(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL add_latency got=%0d exp=8", lat); end
    total++; if (out !== 32'h0 || co !== 1'b1) begin bad++; $display("FAIL add_wrap got=%h/%b exp=0/1", out, co); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done got=%b exp=0", busy); end
`ifdef ADDER_FLAGS_EN
    total++; if ({zr, ov} !== 2'b10) begin bad++; $display("FAIL add_flags got=%b exp=10", {zr, ov}); end
`endif
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done); end
    total++; if (out !== 32'h0 || co !== 1'b1) begin bad++; $display("FAIL out_hold got=%h/%b exp=0/1", out, co); end
  endtask

  task automatic test_sub;
    int lat;
    op32(1'b1, 32'd5, 32'd7, 1'b0, lat);
    total++; if (lat !== 8 || out !== 32'hFFFFFFFE || co !== 1'b0) begin bad++; $display("FAIL sub_neg got=%0d/%h/%b exp=8/fffffffe/0", lat, out, co); end
    @(negedge clk);
    op32(1'b1, 32'd7, 32'd5, 1'b1, lat);
    total++; if (lat !== 8 || out !== 32'h2 || co !== 1'b1) begin bad++; $display("FAIL sub_pos got=%0d/%h/%b exp=8/2/1", lat, out, co); end
    @(negedge clk);
  endtask

  task automatic test_flags;
`ifdef ADDER_FLAGS_EN
    int lat;
    op32(1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, lat);
    total++; if (out !== 32'h80000000 || co !== 1'b0 || ov !== 1'b1 || zr !== 1'b0) begin bad++; $display("FAIL flags_add_ovf got=%h/%b/%b/%b exp=80000000/0/1/0", out, co, ov, zr); end
    @(negedge clk);
    op32(1'b1, 32'h80000000, 32'h1, 1'b0, lat);
    total++; if (out !== 32'h7FFFFFFF || co !== 1'b1 || ov !== 1'b1) begin bad++; $display("FAIL flags_sub_ovf got=%h/%b/%b exp=7fffffff/1/1", out, co, ov); end
    @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    start = 1'b1; sub = 1'b0; in1 = 32'h12345678; in2 = 32'h11111111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2 || lat == 5) begin
        start = 1'b1; sub = 1'b1; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total++; if (lat !== 8 || out !== 32'h23456789 || co !== 1'b0) begin bad++; $display("FAIL ignore_start got=%0d/%h/%b exp=8/23456789/0", lat, out, co); end
    start = 1'b1; sub = 1'b1; in1 = 32'hA; in2 = 32'h3; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b%b exp=01", done, busy); end
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 8 || out !== 32'h7 || co !== 1'b1) begin bad++; $display("FAIL b2b_result got=%0d/%h/%b exp=8/7/1", lat, out, co); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int seen;
    start = 1'b1; sub = 1'b0; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, co} !== 3'b000 || out !== 32'h0) begin bad++; $display("FAIL reset_abort got=%b/%h exp=000/0", {busy, done, co}, out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL no_done_after_abort got=%0d exp=0", seen); end
    op32(1'b0, 32'h80000000, 32'h80000000, 1'b1, lat);
    total++; if (lat !== 8 || out !== 32'h1 || co !== 1'b1) begin bad++; $display("FAIL after_abort got=%0d/%h/%b exp=8/1/1", lat, out, co); end
`ifdef ADDER_FLAGS_EN
    total++; if ({ov, zr} !== 2'b10) begin bad++; $display("FAIL after_abort_flags got=%b exp=10", {ov, zr}); end
`endif
    @(negedge clk);
  endtask

  task automatic test_small;
    int lat;
    start_a = 1'b1; sub_a = 1'b0; in1_a = 8'hC8; in2_a = 8'h64; cin_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 1 || out_a !== 8'h2D || co_a !== 1'b1) begin bad++; $display("FAIL w8d8 got=%0d/%h/%b exp=1/2d/1", lat, out_a, co_a); end
    start_b = 1'b1; sub_b = 1'b0; in1_b = 8'hC8; in2_b = 8'h64; cin_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 8 || out_b !== 8'h2D || co_b !== 1'b1) begin bad++; $display("FAIL w8d1 got=%0d/%h/%b exp=8/2d/1", lat, out_b, co_b); end
    @(negedge clk);
    start_b = 1'b1; sub_b = 1'b1; in1_b = 8'h10; in2_b = 8'h20; cin_b = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 8 || out_b !== 8'hF0 || co_b !== 1'b0) begin bad++; $display("FAIL w8d1_sub got=%0d/%h/%b exp=8/f0/0", lat, out_b, co_b); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_flags;
    test_back_to_back;
    test_reset_mid_run;
    test_small;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
